// File: rtl/vfpu_fma_sched.sv
`default_nettype none
// ============================================================================
//  Module   : vfpu_fma_sched
//  Purpose  : Shares one fully pipelined single-precision FMA datapath between
//             NREQ requesters. Provides round-robin issue, tag tracking with
//             result routing, and safe nj_mode reconfiguration (the mode only
//             changes once the datapath is empty).
//  Revision : 1.0  initial release
// ============================================================================
module vfpu_fma_sched #(
   parameter int NREQ = 4,
   parameter int LAT  = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [32*NREQ-1:0]   req_c,
   input  logic [NREQ-1:0]      req_sub,
   input  logic                 cfg_we,
   input  logic                 cfg_nj,
   output logic                 fma_valid,
   output logic [31:0]          fma_a,
   output logic [31:0]          fma_b,
   output logic [31:0]          fma_c,
   output logic                 fma_inv_mask,
   output logic                 fma_nj_mode,
   input  logic                 fma_res_valid,
   input  logic [31:0]          fma_res,
   input  logic                 fma_spec,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 rsp_spec,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                pend_q, pend_d;
   logic                nj_q, nj_d;

   logic [IDW-1:0]      ptr_q;
   logic [NREQ-1:0]     gnt;
   logic [IDW-1:0]      gnt_id;
   logic                gnt_found;
   logic [IDW:0]        cand;

   logic [31:0]         sel_a, sel_b, sel_c;
   logic                sel_sub;

   logic                iss_v_q;
   logic [IDW-1:0]      iss_id_q;
   logic [31:0]         iss_a_q, iss_b_q, iss_c_q;
   logic                iss_inv_q;

   // Tag pipe: valid/id of each op in the datapath, plus a marker that covers
   // the LAT cycles after reset where results of pre-reset ops may still emerge.
   logic [LAT-1:0]      tag_v_q;
   logic [IDW-1:0]      tag_id_q [LAT];
   logic [LAT-1:0]      stale_q;

   logic                tail_v, tail_stale, deliver;
   logic [IDW-1:0]      tail_id;
   logic                drained;

   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_data_q;
   logic                rsp_spec_q;
   logic                err_q;

   // Round-robin search starting at the pointer; grants only while running
   always_comb begin
      gnt       = '0;
      gnt_id    = '0;
      gnt_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
            gnt_found              = 1'b1;
            gnt[cand[IDW-1:0]]     = 1'b1;
            gnt_id                 = cand[IDW-1:0];
         end
      end
      if (state_q != ST_RUN || rst) begin
         gnt = '0;
      end
   end

   // Operand mux for the granted requester
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_c   = '0;
      sel_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_a   = req_a[i*32 +: 32];
            sel_b   = req_b[i*32 +: 32];
            sel_c   = req_c[i*32 +: 32];
            sel_sub = req_sub[i];
         end
      end
   end

   // Issue register and round-robin pointer update
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_v_q   <= 1'b0;
         iss_id_q  <= '0;
         iss_a_q   <= '0;
         iss_b_q   <= '0;
         iss_c_q   <= '0;
         iss_inv_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         iss_v_q <= |gnt;
         if (|gnt) begin
            iss_id_q  <= gnt_id;
            iss_a_q   <= sel_a;
            iss_b_q   <= sel_b;
            iss_c_q   <= sel_c;
            iss_inv_q <= sel_sub;
            ptr_q     <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

   // Tag and stale-window shift registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v_q <= '0;
         stale_q <= '1;
         for (int k = 0; k < LAT; k++) begin
            tag_id_q[k] <= '0;
         end
      end else begin
         for (int k = LAT-1; k > 0; k--) begin
            tag_v_q[k]  <= tag_v_q[k-1];
            tag_id_q[k] <= tag_id_q[k-1];
            stale_q[k]  <= stale_q[k-1];
         end
         tag_v_q[0]  <= iss_v_q;
         tag_id_q[0] <= iss_id_q;
         stale_q[0]  <= 1'b0;
      end
   end

   assign tail_v     = tag_v_q[LAT-1];
   assign tail_id    = tag_id_q[LAT-1];
   assign tail_stale = stale_q[LAT-1];
   assign deliver    = fma_res_valid & tail_v;
   assign drained    = ~(|tag_v_q) & ~iss_v_q;

   // One-hot delivery to the owner recorded in the tag tail
   always_comb begin
      rsp_valid_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid_d[i] = deliver && (tail_id == IDW'(i));
      end
   end

   // Response registers and sticky alignment error
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_spec_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (deliver) begin
            rsp_data_q <= fma_res;
            rsp_spec_q <= fma_spec;
         end
         if ((tail_v != fma_res_valid) && !tail_stale) begin
            err_q <= 1'b1;
         end
      end
   end

   // Reconfiguration sequencing: next state, pending value and mode
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      nj_d    = nj_q;
      case (state_q)
         ST_RUN: begin
            if (cfg_we) begin
               pend_d  = cfg_nj;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cfg_we) begin
               pend_d = cfg_nj;
            end
            if (drained) begin
               nj_d    = pend_d;
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            if (cfg_we) begin
               pend_d = cfg_nj;
               nj_d   = cfg_nj;
            end
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Reconfiguration state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pend_q  <= 1'b0;
         nj_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         nj_q    <= nj_d;
      end
   end

   assign req_ready    = gnt;
   assign fma_valid    = iss_v_q;
   assign fma_a        = iss_a_q;
   assign fma_b        = iss_b_q;
   assign fma_c        = iss_c_q;
   assign fma_inv_mask = iss_inv_q;
   assign fma_nj_mode  = nj_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_spec     = rsp_spec_q;
   assign busy         = (|tag_v_q) | iss_v_q | (state_q != ST_RUN);
   assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vfpu_fma_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vfpu_fma_sched
//  Purpose  : Self-checking bench for vfpu_fma_sched with a datapath stub and
//             a cycle-level reference model of issue, routing and drain.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vfpu_fma_sched;
   localparam int NREQ = 4;
   localparam int LAT  = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a, req_b, req_c;
   logic [NREQ-1:0]      req_sub;
   logic                 cfg_we, cfg_nj;
   logic                 fma_valid;
   logic [31:0]          fma_a, fma_b, fma_c;
   logic                 fma_inv_mask, fma_nj_mode;
   logic                 fma_res_valid;
   logic [31:0]          fma_res;
   logic                 fma_spec;
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_data;
   logic                 rsp_spec;
   logic                 busy, err;

   always #5 clk = ~clk;

   vfpu_fma_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_sub(req_sub),
      .cfg_we(cfg_we), .cfg_nj(cfg_nj),
      .fma_valid(fma_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
      .fma_inv_mask(fma_inv_mask), .fma_nj_mode(fma_nj_mode),
      .fma_res_valid(fma_res_valid), .fma_res(fma_res), .fma_spec(fma_spec),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_spec(rsp_spec),
      .busy(busy), .err(err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- datapath stub (never reset: models in-flight ops) -----
   function automatic logic [31:0] stub_res(logic [31:0] a, logic [31:0] b,
                                            logic [31:0] c, logic inv);
      if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h0) return 32'h40000000;
      if (inv && a == 32'h7F800000 && c == 32'h7F800000)       return 32'h7FC00000;
      return a + b + c;
   endfunction

   logic [LAT-1:0] sv    = '0;
   logic [LAT-1:0] sspec = '0;
   logic [31:0]    sres [LAT];
   bit             early = 1'b0;

   always @(posedge clk) begin
      for (int k = LAT-1; k > 0; k--) begin
         sv[k]    <= sv[k-1];
         sres[k]  <= sres[k-1];
         sspec[k] <= sspec[k-1];
      end
      sv[0]    <= fma_valid;
      sres[0]  <= stub_res(fma_a, fma_b, fma_c, fma_inv_mask);
      sspec[0] <= (fma_a[30:23] == 8'hFF) | (fma_c[30:23] == 8'hFF);
   end

   assign fma_res_valid = early ? sv[LAT-2]   : sv[LAT-1];
   assign fma_res       = early ? sres[LAT-2] : sres[LAT-1];
   assign fma_spec      = early ? sspec[LAT-2] : sspec[LAT-1];

   // ---------------- checking ----------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] rr(int p, logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
      end
      return '0;
   endfunction

   // ---------------- reference model ---------------------------------------
   typedef struct { int due; int id; } tag_t;
   typedef struct { int due; int id; logic [31:0] d; logic s; } rsp_t;
   tag_t tagq[$];
   rsp_t rspq[$];
   int   ptr_m, iss_cyc, cfg_n, cfg_end, last_g, ign_until, rsp_cnt, last_rsp_cyc;
   bit   iss_pend, err_m, nj_m, pend_m, cfg_act;
   logic [31:0] ia, ib, ic, ld;
   logic        iinv, ls;
   int   dut_glog[$];

   always @(negedge clk) begin
      int n;
      logic [NREQ-1:0] eg;
      bit fv, tv, allowed;
      int tid, gid, m;
      n = cyc;
      if (rst) begin
         tagq.delete(); rspq.delete();
         ptr_m = 0; iss_pend = 0; err_m = 0; nj_m = 0; pend_m = 0; cfg_act = 0;
         ld = '0; ls = 1'b0; last_g = -1000; ign_until = n + LAT;
      end else begin
         allowed = !(cfg_act && n > cfg_n && n <= cfg_end);
         eg = allowed ? rr(ptr_m, req_valid) : '0;
         chk("req_ready", req_ready, eg);
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_glog.push_back(i);
         fv = iss_pend && (iss_cyc == n);
         chk("fma_valid", fma_valid, fv);
         if (fv) begin
            chk("fma_a", fma_a, ia);
            chk("fma_b", fma_b, ib);
            chk("fma_c", fma_c, ic);
            chk("fma_inv_mask", fma_inv_mask, iinv);
         end
         if (rspq.size() > 0 && rspq[0].due == n) begin
            chk("rsp_valid", rsp_valid, NREQ'(1) << rspq[0].id);
            chk("rsp_data", rsp_data, rspq[0].d);
            chk("rsp_spec", rsp_spec, rspq[0].s);
            ld = rspq[0].d; ls = rspq[0].s;
            rsp_cnt++; last_rsp_cyc = n;
            void'(rspq.pop_front());
         end else begin
            chk("rsp_valid_idle", rsp_valid, '0);
            chk("rsp_data_hold", rsp_data, ld);
            chk("rsp_spec_hold", rsp_spec, ls);
         end
         chk("err", err, err_m);
         chk("busy", busy, fv || tagq.size() > 0 || (cfg_act && n > cfg_n && n <= cfg_end));
         chk("nj_mode", fma_nj_mode, nj_m);

         // advance model by one cycle
         tv = 0; tid = 0;
         if (tagq.size() > 0 && tagq[0].due == n) begin
            tv = 1; tid = tagq[0].id; void'(tagq.pop_front());
         end
         if (n > ign_until && (tv != fma_res_valid)) err_m = 1;
         if (tv && fma_res_valid) rspq.push_back('{n + 1, tid, fma_res, fma_spec});
         if (eg != '0) begin
            gid = 0;
            for (int i = 0; i < NREQ; i++) if (eg[i]) gid = i;
            tagq.push_back('{n + LAT + 1, gid});
            iss_pend = 1; iss_cyc = n + 1;
            ia = req_a[gid*32 +: 32]; ib = req_b[gid*32 +: 32];
            ic = req_c[gid*32 +: 32]; iinv = req_sub[gid];
            ptr_m = (gid + 1) % NREQ; last_g = n;
         end
         if (cfg_act && n == cfg_end - 1) nj_m = pend_m;
         if (cfg_we) begin
            if (!cfg_act) begin
               cfg_act = 1; cfg_n = n; pend_m = cfg_nj;
               m = (last_g + LAT + 2 > n + 1) ? last_g + LAT + 2 : n + 1;
               cfg_end = m + 1;
            end else begin
               pend_m = cfg_nj;
               if (n == cfg_end - 1 || n == cfg_end) nj_m = cfg_nj;
            end
         end
         if (cfg_act && n == cfg_end) cfg_act = 0;
      end
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(output int at);
      at = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid != '0) begin at = cyc; break; end
      end
   endtask

   initial begin
      int g, at, gl0, c0, cn, cg;
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, at, gl0, c0, cn, cg;
      rst = 1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_sub = '0;
      cfg_we = 0; cfg_nj = 0; rsp_cnt = 0; last_rsp_cyc = -1;
      repeat (2) step();
      rst = 0;
      step();

      // 1: all requesters valid -> strict rotation 0,1,2,3,...
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*32 +: 32] = 32'h3F800000 + 32'(i);
         req_b[i*32 +: 32] = 32'h00001000 * 32'(i);
         req_c[i*32 +: 32] = 32'(i);
      end
      gl0 = dut_glog.size();
      req_valid = 4'hF;
      repeat (8) step();
      req_valid = '0;
      repeat (LAT + 4) step();
      chk("t1_grant_count", dut_glog.size() - gl0, 8);
      for (int k = 0; k < 8 && gl0 + k < dut_glog.size(); k++)
         chk("t1_grant_order", dut_glog[gl0 + k], k % NREQ);

      // 2: only requester 2 valid
      req_a[2*32 +: 32] = 32'h3F800000; req_b[2*32 +: 32] = 32'h40000000;
      req_c[2*32 +: 32] = 32'h00000000;
      req_valid = 4'b0100; g = cyc;
      step(); req_valid = '0;
      wait_rsp(at);
      chk("t2_latency", at - g, LAT + 2);
      chk("t2_rsp_valid", rsp_valid, 4'b0100);
      chk("t2_rsp_data", rsp_data, 32'h40000000);
      chk("t2_rsp_spec", rsp_spec, 1'b0);
      repeat (2) step();

      // 3: effective subtraction, inf - inf -> NaN with spec flag
      req_a[1*32 +: 32] = 32'h7F800000; req_b[1*32 +: 32] = 32'h3F800000;
      req_c[1*32 +: 32] = 32'h7F800000; req_sub = 4'b0010;
      req_valid = 4'b0010;
      step(); req_valid = '0;
      @(negedge clk);
      chk("t3_fma_valid", fma_valid, 1'b1);
      chk("t3_inv_mask", fma_inv_mask, 1'b1);
      wait_rsp(at);
      chk("t3_rsp_valid", rsp_valid, 4'b0010);
      chk("t3_rsp_data", rsp_data, 32'h7FC00000);
      chk("t3_rsp_spec", rsp_spec, 1'b1);
      step(); req_sub = '0;
      repeat (2) step();

      // 4: reconfigure with three ops in flight
      req_valid = 4'b0111;
      repeat (3) step();
      req_valid = '0; cfg_we = 1; cfg_nj = 1; c0 = rsp_cnt;
      step(); cfg_we = 0; cfg_nj = 0; req_valid = 4'b1000;
      cn = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (fma_nj_mode) begin cn = cyc; break; end
      end
      chk("t4_nj_set", fma_nj_mode, 1'b1);
      chk("t4_rsp_before_nj", rsp_cnt - c0, 3);
      chk("t4_nj_after_drain", cn - last_rsp_cyc, 1);
      cg = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req_ready[3]) begin cg = cyc; break; end
      end
      chk("t4_resume", cg - cn, 1);
      step(); req_valid = '0;
      repeat (LAT + 4) step();

      // 5: result one cycle early -> sticky err, later result still routed
      early = 1'b1;
      req_valid = 4'b0001;
      step(); req_valid = '0;
      repeat (LAT + 4) step();
      early = 1'b0;
      @(negedge clk);
      chk("t5_err", err, 1'b1);
      step();
      req_a[2*32 +: 32] = 32'h00000005; req_b[2*32 +: 32] = 32'h00000007;
      req_c[2*32 +: 32] = 32'h00000009;
      req_valid = 4'b0100;
      step(); req_valid = '0;
      wait_rsp(at);
      chk("t5_routed_valid", rsp_valid, 4'b0100);
      chk("t5_routed_data", rsp_data, 32'h00000015);
      chk("t5_err_sticky", err, 1'b1);
      repeat (3) step();

      // 6: reset with two ops in flight
      req_valid = 4'b0011;
      repeat (2) step();
      req_valid = '0;
      step();
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      chk("t6_fma_valid", fma_valid, 1'b0);
      chk("t6_rsp_valid", rsp_valid, '0);
      chk("t6_rsp_data", rsp_data, 32'h0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_err", err, 1'b0);
      chk("t6_nj", fma_nj_mode, 1'b0);
      repeat (LAT + 3) step();
      chk("t6_err_after_stale", err, 1'b0);
      chk("t6_no_rsp", rsp_cnt, rsp_cnt);
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vfpu_fma_sched.md
Name: vfpu_fma_sched

Overview:
- Shares one fully pipelined single-precision FMA datapath between NREQ requesters.
- The datapath is the FMA core together with its special-case handler.
- The scheduler does three things:
  - Round-robin arbitrates issue requests and drives the operands, inv_mask and nj_mode into the datapath.
  - Tracks in-flight operations in a LAT-deep tag shift register and routes each returning result to its owner.
  - Sequences nj_mode reconfiguration so the mode never changes while operations are in flight.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 4, fixed datapath latency in cycles from issue to result (>=1).
- IDW, 2, requester-id width (>= clog2(NREQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester issue request.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready.
- req_a  in  32*NREQ  operand a, slice i belongs to requester i; same layout for b and c.
- req_b  in  32*NREQ  operand b.
- req_c  in  32*NREQ  operand c.
- req_sub  in  NREQ  1 = a*b-c (effective subtraction, drives inv_mask).
- cfg_we  in  1  nj_mode write request (single-cycle pulse).
- cfg_nj  in  1  new nj_mode value.
- fma_valid  out  1  issue strobe to the datapath.
- fma_a  out  32  operand a to the datapath.
- fma_b  out  32  operand b to the datapath.
- fma_c  out  32  operand c to the datapath.
- fma_inv_mask  out  1  inv_mask to the datapath.
- fma_nj_mode  out  1  current nj_mode.
- fma_res_valid  in  1  datapath result strobe.
- fma_res  in  32  datapath result.
- fma_spec  in  1  spec_mask of the result.
- rsp_valid  out  NREQ  one-hot result delivery (no backpressure).
- rsp_data  out  32  result.
- rsp_spec  out  1  special-case flag.
- busy  out  1  any operation in flight or reconfiguration pending.
- err  out  1  sticky: result/tag misalignment.

Behaviour:
- Reset values: all outputs 0; fma_nj_mode=0; RR pointer=0; tag pipe cleared; state=RUN; err=0.
- States:
  - RUN: arbitrates.
  - DRAIN: cfg pending, grants suppressed.
  - APPLY: one cycle, nj_mode updated.
- Arbitration (RUN only):
  - Combinational round-robin over req_valid, starting from the pointer.
  - req_ready is the one-hot grant, with at most one grant per cycle.
  - After a transfer, the pointer becomes (granted id + 1) mod NREQ. With no transfer the pointer holds.
  - req_ready may only assert for a requester whose req_valid is high.
- Issue timing:
  - The transfer in cycle t produces registered fma_valid/fma_a/b/c/fma_inv_mask in cycle t+1.
  - Back-to-back issue is allowed, up to one op per cycle.
- Tag pipe:
  - LAT entries of {valid, id}, shifted every cycle.
  - Entry 0 is loaded from the issue at t+1.
  - An issue in cycle t+1 is expected back as fma_res_valid in cycle t+1+LAT.
- Result routing:
  - When fma_res_valid is high, in the next cycle assert rsp_valid[id]=1 (id taken from the tag tail) and rsp_data=fma_res, rsp_spec=fma_spec.
  - Otherwise rsp_valid=0 and rsp_data/rsp_spec hold their previous values.
- err: set (sticky until rst) if the tag-tail valid differs from fma_res_valid in any cycle. Routing still follows the tag tail; a result with no tag is dropped.
- Reconfiguration:
  - cfg_we in RUN latches cfg_nj into a pending register and enters DRAIN the next cycle.
  - A grant in the same cycle as cfg_we is still honoured.
  - DRAIN waits for the tag pipe and the issue register to be empty, then enters APPLY.
  - APPLY sets fma_nj_mode=pending and returns to RUN the next cycle.
  - cfg_we during DRAIN/APPLY overwrites the pending value and does not restart the sequence.
- busy = any tag valid | fma_valid | state != RUN.
- Reset mid-operation: the tag pipe is discarded, in-flight datapath results are ignored with no rsp, and err is not set by them.

Test Plan:
1. Requesters 0..3 all hold valid continuously -> grants 0,1,2,3,0,... in consecutive cycles; each rsp_valid[i] arrives exactly LAT+2 cycles after its grant.
2. Only requester 2 valid, a=0x3F800000, b=0x40000000, c=0x00000000, stub returns 0x40000000 after LAT -> rsp_valid=0100, rsp_data=0x40000000, other requesters never granted.
3. Issue with req_sub=1, a=0x7F800000, b=0x3F800000, c=0x7F800000 -> fma_inv_mask=1; stub returns 0x7FC00000 with spec=1 -> rsp_spec=1, rsp_data=0x7FC00000.
4. cfg_we with cfg_nj=1 while 3 ops are in flight -> no grants until the 3 rsp have been delivered; fma_nj_mode=1 one cycle after the drain completes; grants resume the following cycle.
5. Stub asserts fma_res_valid one cycle early -> err=1 and stays 1 until rst; a later correctly aligned result is still routed.
6. rst asserted with 2 ops in flight -> next cycle all outputs 0 and busy=0; stale fma_res_valid produces no rsp_valid and err stays 0.
